// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state, opcode and datapath select encodings for the multi-cycle RV32I controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_TRAP
    } state_t;

    typedef enum logic [1:0] {CLS_ADD, CLS_RTYPE, CLS_BRANCH} alu_cls_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_SUM     = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: picks the ALU operation from the opcode, funct7[5] and the class of the current state.
module alu_decoder
    import ctrl_pkg::*;
#(
    parameter int OP_W = 7
) (
    input  logic [OP_W-1:0] op,
    input  logic            funct7_5,
    input  alu_cls_t        cls,
    output logic [2:0]      ALUctrl
);

    assign ALUctrl = (cls == CLS_BRANCH || (cls == CLS_RTYPE && op == OP_R && funct7_5)) ? ALU_SUB : ALU_ADD;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM driving the shared-ALU datapath.
// ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP and raise a sticky illegal flag.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 7,
    parameter int STATE_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            EQ,
    input  logic            mem_ready,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            AdrSrc,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            RegWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUsrcA,
    output logic [1:0]      ALUsrcB,
    output logic [2:0]      ALUctrl,
    output logic [2:0]      ImmSrc,
    output logic            illegal
);

    generate
        if (STATE_W < $bits(state_t)) begin : g_state_w_chk
            $error("STATE_W too small for state_t");
        end
    endgenerate

    state_t   state_q, state_d;
    alu_cls_t cls;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t S_UNKNOWN = S_TRAP;
    logic illegal_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    localparam state_t S_UNKNOWN = S_FETCH;
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_FETCH;
        else state_q <= state_d;
    end

    // Everything is forced low while rst is held, so the reset state's Moore outputs never leak.
    always_comb begin
        state_d   = state_q;
        cls       = CLS_ADD;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUsrcA   = SRCA_PC;
        ALUsrcB   = SRCB_RS2;
        ImmSrc    = IMM_I;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    MemRead   = 1'b1;
                    ALUsrcB   = SRCB_FOUR;
                    ResultSrc = RES_SUM;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    state_d   = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    ALUsrcA = SRCA_OLDPC;
                    ALUsrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXEC_R;
                        OP_I:              state_d = S_EXEC_I;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_LUI:            state_d = S_LUI;
                        default:           state_d = S_UNKNOWN;
                    endcase
                end
                S_MEMADR: begin
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                    state_d = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    AdrSrc  = 1'b1;
                    state_d = mem_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    RegWrite  = mem_ready;
                    ResultSrc = RES_MEMDATA;
                    state_d   = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite = mem_ready;
                    AdrSrc   = 1'b1;
                    state_d  = mem_ready ? S_FETCH : S_MEMWR;
                end
                S_EXEC_R: begin
                    cls     = CLS_RTYPE;
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_RS2;
                    state_d = S_ALUWB;
                end
                S_EXEC_I: begin
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_IMM;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    cls     = CLS_BRANCH;
                    ALUsrcA = SRCA_RS1;
                    ALUsrcB = SRCB_RS2;
                    PCWrite = (funct3 == F3_BEQ) ? EQ : (funct3 == F3_BNE) ? !EQ : 1'b0;
                    state_d = S_FETCH;
                end
                S_JAL: begin
                    ALUsrcA   = SRCA_OLDPC;
                    ALUsrcB   = SRCB_FOUR;
                    RegWrite  = 1'b1;
                    PCWrite   = 1'b1;
                    ResultSrc = RES_SUM;
                    state_d   = S_FETCH;
                end
                S_LUI: begin
                    ALUsrcA = SRCA_ZERO;
                    ALUsrcB = SRCB_IMM;
                    ImmSrc  = IMM_U;
                    state_d = S_ALUWB;
                end
                default: ;
            endcase
        end
    end

    alu_decoder #(.OP_W(OP_W)) u_alu_decoder (
        .op       (op),
        .funct7_5 (funct7_5),
        .cls      (cls),
        .ALUctrl  (ALUctrl)
    );

endmodule
